req_pending_encoder: RTL and testbench

Sequential front end for the 8-line encoder path. It captures request events on 8 input lines into a pending register and offers the highest-priority pending index as a 3-bit code with a valid/ready handshake. The offered index is cleared when the consumer accepts it. Downstream logic receives one registered, stable code per accepted request instead of raw multi-hot lines.

---
 rtl/req_pending_encoder_pkg.sv | 27 ++
 rtl/req_pending_encoder_prio.sv | 27 ++
 rtl/req_pending_encoder.sv | 127 ++++++++++++
 tb/tb_req_pending_encoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_pending_encoder_pkg.sv
// enc_pkg: shared definitions for the request pending encoder slice.
//   N_REQ       number of request lines (power of two, >= 2)
//   IDX_W       width of an encoded line index
//   enc_state_t offer FSM states
//   prio_idx()  highest-set-bit index of an N_REQ-wide vector
package enc_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } enc_state_t;

  // Scanning upward lets the highest set bit overwrite lower ones, so
  // bit N_REQ-1 has top priority. An all-zero vector encodes as 0.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int b = 0; b < N_REQ; b++) begin
      if (vec[b]) idx = IDX_W'(b);
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_pending_encoder_prio.sv
// prio_enc8: combinational priority encoder, highest set bit wins.
// Ports:
//   vec  in  N      vector to encode
//   idx  out IDX_W  index of the highest set bit (0 when vec is empty)
//   any  out 1      vec has at least one bit set
module prio_enc8
  import enc_pkg::*;
#(
  parameter int N  = N_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Upward scan so the highest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int b = 0; b < N; b++) begin
      if (vec[b]) idx = IW'(b);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_pending_encoder.sv
// req_pending_encoder: captures request events on N lines into a pending
// register and offers the highest-priority pending index with a
// valid/ready handshake. One registered code per accepted request.
//
// Configuration macro: REQ_EDGE_DETECT_EN
//   defined   : events are rising edges of i (i_q register present),
//               lost flags an event that hits an already-pending bit
//   undefined : level mode, every high line re-asserts its pending bit
//               each cycle; lost is tied to 0
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   en         in  1      capture enable (pending bits drain regardless)
//   i          in  N      request lines
//   out        out IDX_W  offered index
//   out_valid  out 1      out holds a pending index
//   out_ready  in  1      consumer accepts out this cycle
//   pending    out N      current pending register
//   lost       out 1      one-cycle pulse, event hit an already-pending bit
module req_pending_encoder
  import enc_pkg::*;
#(
  parameter int N     = N_REQ,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     i,
  output logic [IDX_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             lost
);

  enc_state_t       state;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     ev;
  logic [N-1:0]     clr;
  logic [N-1:0]     pend_n;
  logic [IDX_W-1:0] next_idx;
  logic             next_any;

`ifdef REQ_EDGE_DETECT_EN
  logic [N-1:0] i_q;
  logic         lost_q;

  // Previous-cycle copy of the request lines. Tracks i even while capture
  // is disabled so re-enabling never produces a stale edge.
  always_ff @(posedge clk) begin
    if (rst) i_q <= '0;
    else     i_q <= i;
  end

  assign ev = (i & ~i_q) & {N{en}};

  // An event only counts as lost when the bit is already pending and is
  // not being cleared this cycle; set-wins re-offers it instead.
  always_ff @(posedge clk) begin
    if (rst) lost_q <= 1'b0;
    else     lost_q <= |(ev & pending & ~clr);
  end

  assign lost = lost_q;
`else
  assign ev   = i & {N{en}};
  assign lost = 1'b0;
`endif

  // Clear the offered bit on a handshake, then merge new events on top so
  // a set in the same cycle wins over the clear.
  always_comb begin
    clr = '0;
    if (out_valid && out_ready) clr[idx_q] = 1'b1;
    pend_n = (pending & ~clr) | ev;
  end

  prio_enc8 #(
    .N  (N),
    .IW (IDX_W)
  ) u_prio (
    .vec (pend_n),
    .idx (next_idx),
    .any (next_any)
  );

  // Offer FSM. idx_q is only reloaded on entry to OFFER or after an
  // accept, so a higher-priority arrival never preempts a stalled offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx_q     <= '0;
      out_valid <= 1'b0;
      pending   <= '0;
    end else begin
      pending <= pend_n;
      case (state)
        IDLE: begin
          if (next_any) begin
            idx_q     <= next_idx;
            state     <= OFFER;
            out_valid <= 1'b1;
          end
        end
        OFFER: begin
          if (out_ready) begin
            if (next_any) begin
              idx_q <= next_idx;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out = idx_q;

endmodule

// File: tb/tb_req_pending_encoder.sv
// tb_req_pending_encoder: directed self-checking bench for
// req_pending_encoder. Edge-mode scenarios are compiled in when
// REQ_EDGE_DETECT_EN is defined; level-mode scenarios otherwise.
module tb_req_pending_encoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] i;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       lost;

  int checks;
  int failures;

  req_pending_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i         (i),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .lost      (lost)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs are
  // sampled at this point, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; i = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || pending !== 8'h00 || out !== 3'd0 || lost !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold cyc%0d: got valid=%b pend=%h out=%0d lost=%b expected 0/00/0/0",
                 c, out_valid, pending, out, lost);
      end
    end
    rst = 1'b0; i = 8'h00; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_release: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_single();
    i = 8'h04; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd2 || pending !== 8'h04) begin
      failures++;
      $display("[TB] FAIL single_offer: got valid=%b out=%0d pend=%h expected 1/2/04", out_valid, out, pending);
    end
    i = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || lost !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_accept: got valid=%b pend=%h lost=%b expected 0/00/0", out_valid, pending, lost);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_out  [3];
    logic [7:0] exp_pend [3];
    exp_out  = '{3'd7, 3'd4, 3'd0};
    exp_pend = '{8'h91, 8'h11, 8'h01};
    i = 8'h91; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      i = 8'h00;
      checks++;
      if (out_valid !== 1'b1 || out !== exp_out[c] || pending !== exp_pend[c]) begin
        failures++;
        $display("[TB] FAIL priority step%0d: got valid=%b out=%0d pend=%h expected 1/%0d/%h",
                 c, out_valid, out, pending, exp_out[c], exp_pend[c]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL priority_drain: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0; i = 8'h02;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd1) begin
      failures++;
      $display("[TB] FAIL stall_first: got valid=%b out=%0d expected 1/1", out_valid, out);
    end
    i = 8'h80;
    tick();
    checks++;
    if (out !== 3'd1 || pending !== 8'h82) begin
      failures++;
      $display("[TB] FAIL stall_no_preempt: got out=%0d pend=%h expected 1/82", out, pending);
    end
    i = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd1) begin
      failures++;
      $display("[TB] FAIL stall_hold: got valid=%b out=%0d expected 1/1", out_valid, out);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd7 || pending !== 8'h80) begin
      failures++;
      $display("[TB] FAIL stall_after_accept: got valid=%b out=%0d pend=%h expected 1/7/80", out_valid, out, pending);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL stall_drain: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_enable();
    en = 1'b1; out_ready = 1'b0; i = 8'h05;
    tick();
    i = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd2 || pending !== 8'h05) begin
      failures++;
      $display("[TB] FAIL enable_setup: got valid=%b out=%0d pend=%h expected 1/2/05", out_valid, out, pending);
    end
    en = 1'b0; i = 8'h10; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd0 || pending !== 8'h01) begin
      failures++;
      $display("[TB] FAIL enable_ignored: got valid=%b out=%0d pend=%h expected 1/0/01", out_valid, out, pending);
    end
    i = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL enable_drain: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
    en = 1'b1; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL enable_restore: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_reset_mid_offer();
    out_ready = 1'b0; i = 8'h0C;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd3 || pending !== 8'h0C) begin
      failures++;
      $display("[TB] FAIL midrst_setup: got valid=%b out=%0d pend=%h expected 1/3/0C", out_valid, out, pending);
    end
    i = 8'h00; rst = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00 || out !== 3'd0) begin
      failures++;
      $display("[TB] FAIL midrst_drop: got valid=%b pend=%h out=%0d expected 0/00/0", out_valid, pending, out);
    end
    rst = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL midrst_after: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

`ifdef REQ_EDGE_DETECT_EN
  task automatic test_lost();
    out_ready = 1'b0; i = 8'h08;
    tick();
    i = 8'h00;
    checks++;
    if (pending !== 8'h08 || lost !== 1'b0 || out !== 3'd3) begin
      failures++;
      $display("[TB] FAIL lost_setup: got pend=%h lost=%b out=%0d expected 08/0/3", pending, lost, out);
    end
    tick();
    i = 8'h08;
    tick();
    i = 8'h00;
    checks++;
    if (lost !== 1'b1 || pending !== 8'h08) begin
      failures++;
      $display("[TB] FAIL lost_pulse: got lost=%b pend=%h expected 1/08", lost, pending);
    end
    tick();
    checks++;
    if (lost !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lost_one_cycle: got lost=%b expected 0", lost);
    end
    i = 8'h08; out_ready = 1'b1;
    tick();
    i = 8'h00;
    checks++;
    if (lost !== 1'b0 || pending !== 8'h08 || out_valid !== 1'b1 || out !== 3'd3) begin
      failures++;
      $display("[TB] FAIL lost_set_wins: got lost=%b pend=%h valid=%b out=%0d expected 0/08/1/3",
               lost, pending, out_valid, out);
    end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL lost_drain: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask

  task automatic test_edge_track();
    en = 1'b0; i = 8'h10;
    tick();
    en = 1'b1;
    tick();
    checks++;
    if (pending !== 8'h00 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL edge_no_stale: got pend=%h valid=%b expected 00/0", pending, out_valid);
    end
    i = 8'h00;
    tick();
  endtask
`else
  task automatic test_level_reassert();
    out_ready = 1'b1; i = 8'h02;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out !== 3'd1 || pending !== 8'h02 || lost !== 1'b0) begin
      failures++;
      $display("[TB] FAIL level_reassert: got valid=%b out=%0d pend=%h lost=%b expected 1/1/02/0",
               out_valid, out, pending, lost);
    end
    i = 8'h00;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      failures++;
      $display("[TB] FAIL level_drain: got valid=%b pend=%h expected 0/00", out_valid, pending);
    end
  endtask
`endif

  // Scenario sequence; each task leaves the DUT idle with i=0.
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; i = 8'h00; out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_priority();
    test_stall();
    test_enable();
    test_reset_mid_offer();
`ifdef REQ_EDGE_DETECT_EN
    test_lost();
    test_edge_track();
`else
    test_level_reassert();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
